// File: rtl/axis_s2mm_cmd_sched.sv
// Round-robin DataMover S2MM command scheduler over NUM_CH circular DDR buffers.
// Optional build macro: STS_ERR_HALT_EN (error status halts the channel until re-enabled).
module axis_s2mm_cmd_sched #(
    parameter int NUM_CH          = 4,
    parameter int BTT_WIDTH       = 23,
    parameter int BURST_LEN       = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic [71:0]          m_axis_cmd_tdata,
    output logic                 m_axis_cmd_tvalid,
    input  logic                 m_axis_cmd_tready,
    input  logic [7:0]           s_axis_sts_tdata,
    input  logic                 s_axis_sts_tvalid,
    output logic                 s_axis_sts_tready,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*32-1:0] ch_base_addr,
    input  logic [NUM_CH*32-1:0] ch_ring_size,
    output logic [NUM_CH-1:0]    ch_grant,
    output logic [NUM_CH-1:0]    ch_done,
    output logic [NUM_CH-1:0]    ch_err,
    output logic [NUM_CH-1:0]    ch_wrap,
    output logic [3:0]           outstanding
);
    localparam logic [1:0] IDLE = 2'd0, ARB = 2'd1, SEND = 2'd2;
    localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

    logic [1:0]              state;
    logic [NUM_CH-1:0][31:0] ptr;
    logic [NUM_CH-1:0]       en_q, en_rise, en_fall, halted, eligible;
    logic [3:0]              last_ch, sel_ch, cur_ch, sts_tag;
    logic                    sel_vld, sel_wrap, wrap_q, hs, sts_ok, sts_bad, sts_err_q;
    logic [31:0]             sel_base, sel_end, sel_ptr, sel_btt, sel_next, nxt_ptr_q;
    logic [71:0]             cmd;

    assign s_axis_sts_tready = 1'b1;
    assign en_rise  = ch_enable & ~en_q;
    assign en_fall  = ~ch_enable & en_q;
    assign eligible = ch_enable & ch_req & ~halted & {NUM_CH{outstanding < MAX_OS}};
    assign hs       = m_axis_cmd_tvalid & m_axis_cmd_tready;
    assign sts_tag  = s_axis_sts_tdata[3:0];
    assign sts_bad  = !s_axis_sts_tdata[7] || (|s_axis_sts_tdata[6:4]);
    // Stray tags and beats with nothing outstanding never touch channel state.
    assign sts_ok   = s_axis_sts_tvalid && ({1'b0, sts_tag} < 5'(NUM_CH)) && (outstanding != 4'd0);

    // Round-robin: the smallest distance past the last granted channel wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_ch  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (eligible[i] && ((int'(last_ch) + k) % NUM_CH) == i) begin
                    sel_vld = 1'b1;
                    sel_ch  = i[3:0];
                end
            end
        end
    end

    always_comb begin
        sel_base = '0;
        sel_end  = '0;
        sel_ptr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ch == i[3:0]) begin
                sel_base = ch_base_addr[32*i +: 32];
                sel_end  = ch_base_addr[32*i +: 32] + ch_ring_size[32*i +: 32];
                sel_ptr  = ptr[i];
            end
        end
        sel_btt  = ((sel_end - sel_ptr) < 32'(BURST_LEN)) ? (sel_end - sel_ptr) : 32'(BURST_LEN);
        sel_next = sel_ptr + sel_btt;
        sel_wrap = (sel_next == sel_end);
        cmd                  = '0;
        cmd[BTT_WIDTH-1:0]   = sel_btt[BTT_WIDTH-1:0];
        cmd[23]              = 1'b1;
        cmd[31:30]           = 2'b11;
        cmd[63:32]           = sel_ptr;
        cmd[67:64]           = sel_ch;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_grant[i] = hs && (cur_ch == i[3:0]);
            ch_wrap[i]  = hs && wrap_q && (cur_ch == i[3:0]);
            ch_done[i]  = sts_ok && (sts_tag == i[3:0]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            m_axis_cmd_tvalid <= 1'b0;
            m_axis_cmd_tdata  <= '0;
            cur_ch            <= '0;
            last_ch           <= 4'(NUM_CH - 1);
            nxt_ptr_q         <= '0;
            wrap_q            <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|eligible) state <= ARB;
                ARB: begin
                    if (sel_vld) begin
                        state             <= SEND;
                        m_axis_cmd_tvalid <= 1'b1;
                        m_axis_cmd_tdata  <= cmd;
                        cur_ch            <= sel_ch;
                        last_ch           <= sel_ch;
                        nxt_ptr_q         <= sel_wrap ? sel_base : sel_next;
                        wrap_q            <= sel_wrap;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: if (m_axis_cmd_tready) begin
                    m_axis_cmd_tvalid <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= '0;
            sts_err_q   <= 1'b0;
        end else begin
            case ({hs, sts_ok})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
            if (s_axis_sts_tvalid && !sts_ok) sts_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr    <= '0;
            en_q   <= '0;
            ch_err <= '0;
        end else begin
            en_q <= ch_enable;
            for (int i = 0; i < NUM_CH; i++) begin
                if (en_rise[i])       ptr[i] <= ch_base_addr[32*i +: 32];
                else if (ch_grant[i]) ptr[i] <= nxt_ptr_q;
                if (en_fall[i])                   ch_err[i] <= 1'b0;
                else if (ch_done[i] && sts_bad)   ch_err[i] <= 1'b1;
            end
        end
    end

`ifdef STS_ERR_HALT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            halted <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (en_fall[i])                 halted[i] <= 1'b0;
                else if (ch_done[i] && sts_bad) halted[i] <= 1'b1;
            end
        end
    end
`else
    assign halted = '0;
`endif

endmodule

// File: tb/tb_axis_s2mm_cmd_sched.sv
// Bench for axis_s2mm_cmd_sched: ring table vectors, corner sequences, randomized run vs. model.
module tb_axis_s2mm_cmd_sched;
    localparam int NCH = 4;

    logic           clk = 0, resetn = 0;
    logic [71:0]    m_axis_cmd_tdata;
    logic           m_axis_cmd_tvalid, m_axis_cmd_tready = 0;
    logic [7:0]     s_axis_sts_tdata = 0;
    logic           s_axis_sts_tvalid = 0, s_axis_sts_tready;
    logic [NCH-1:0] ch_enable = 0, ch_req = 0;
    logic [NCH*32-1:0] ch_base_addr = 0, ch_ring_size = 0;
    logic [NCH-1:0] ch_grant, ch_done, ch_err, ch_wrap;
    logic [3:0]     outstanding;

    axis_s2mm_cmd_sched #(.NUM_CH(NCH), .BTT_WIDTH(23), .BURST_LEN(4096), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .resetn(resetn),
        .m_axis_cmd_tdata(m_axis_cmd_tdata), .m_axis_cmd_tvalid(m_axis_cmd_tvalid),
        .m_axis_cmd_tready(m_axis_cmd_tready),
        .s_axis_sts_tdata(s_axis_sts_tdata), .s_axis_sts_tvalid(s_axis_sts_tvalid),
        .s_axis_sts_tready(s_axis_sts_tready),
        .ch_enable(ch_enable), .ch_req(ch_req), .ch_base_addr(ch_base_addr),
        .ch_ring_size(ch_ring_size), .ch_grant(ch_grant), .ch_done(ch_done),
        .ch_err(ch_err), .ch_wrap(ch_wrap), .outstanding(outstanding));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] m_base[NCH], m_size[NCH], m_ptr[NCH];
    bit          m_err[NCH], m_halt[NCH];
    int          m_out = 0, m_last = NCH - 1;
    int          tagq[$];

    typedef struct {
        bit          reload;
        logic [31:0] base, size, ptr, btt;
        bit          wrap;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no command within budget, expected one", nm);
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] err_vec();
        logic [3:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_err[i];
        return v;
    endfunction

    function automatic int m_pick(input logic [3:0] req);
        for (int k = 1; k <= NCH; k++) begin
            int idx;
            idx = (m_last + k) % NCH;
            if (req[idx] && ch_enable[idx] && !m_halt[idx] && m_out < 4) return idx;
        end
        return -1;
    endfunction

    task automatic sts_model(input int tag, input logic [3:0] flags);
        m_out--;
        if (flags != 4'h8) begin
            m_err[tag] = 1;
`ifdef STS_ERR_HALT_EN
            m_halt[tag] = 1;
`endif
        end
        for (int i = 0; i < tagq.size(); i++)
            if (tagq[i] == tag) begin tagq.delete(i); break; end
    endtask

    task automatic model_reset();
        m_out = 0; m_last = NCH - 1; tagq.delete();
        for (int i = 0; i < NCH; i++) begin
            m_err[i] = 0; m_halt[i] = 0;
            m_ptr[i] = ch_enable[i] ? m_base[i] : 32'h0;
        end
    endtask

    task automatic wait_valid(output bit ok);
        int w;
        w = 0;
        while (m_axis_cmd_tvalid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        ok = (m_axis_cmd_tvalid === 1'b1);
    endtask

    task automatic cfg(input int ch, input logic [31:0] base, input logic [31:0] size);
        ch_enable[ch] = 0;
        @(negedge clk);
        ch_base_addr[32*ch +: 32] = base;
        ch_ring_size[32*ch +: 32] = size;
        ch_enable[ch] = 1;
        @(negedge clk);
        m_base[ch] = base; m_size[ch] = size; m_ptr[ch] = base;
        m_err[ch] = 0; m_halt[ch] = 0;
        chk("cfg_err_clear", ch_err, err_vec());
    endtask

    task automatic send_sts(input logic [3:0] tag, input logic [3:0] flags);
        bit ok;
        ok = (tag < NCH) && (m_out > 0);
        s_axis_sts_tdata = {flags, tag};
        s_axis_sts_tvalid = 1;
        #1;
        chk("sts_done", ch_done, ok ? oh(int'(tag)) : 4'h0);
        chk("sts_tready", s_axis_sts_tready, 1'b1);
        @(negedge clk);
        s_axis_sts_tvalid = 0;
        if (ok) sts_model(int'(tag), flags);
        #1;
        chk("sts_outstanding", outstanding, 4'(m_out));
        chk("sts_err", ch_err, err_vec());
    endtask

    // Accept the next command; expected channel, address and length come from the model.
    task automatic take_cmd(input int stall, input int sim_tag, input logic [3:0] sim_flags);
        int ch;
        bit ok, wr, sok;
        logic [31:0] p, endv, btt;
        logic [71:0] exp;
        ch = m_pick(ch_req);
        wait_valid(ok);
        if (!ok || ch < 0) begin fail_timeout("cmd_wait"); return; end
        p = m_ptr[ch];
        endv = m_base[ch] + m_size[ch];
        btt = endv - p;
        if (btt > 32'd4096) btt = 32'd4096;
        wr = (p + btt == endv);
        exp = {4'h0, 4'(ch), p, 8'hC0, 1'b1, btt[22:0]};
        chk("cmd_tdata", m_axis_cmd_tdata, exp);
        for (int s = 0; s < stall; s++) begin
            chk("bp_grant", ch_grant, 4'h0);
            @(negedge clk);
            chk("bp_tvalid", m_axis_cmd_tvalid, 1'b1);
            chk("bp_tdata", m_axis_cmd_tdata, exp);
        end
        sok = 0;
        if (sim_tag >= 0) begin
            sok = (sim_tag < NCH) && (m_out > 0);
            s_axis_sts_tdata = {sim_flags, 4'(sim_tag)};
            s_axis_sts_tvalid = 1;
        end
        m_axis_cmd_tready = 1;
        #1;
        chk("hs_grant", ch_grant, oh(ch));
        chk("hs_wrap", ch_wrap, wr ? oh(ch) : 4'h0);
        if (sim_tag >= 0) chk("hs_done", ch_done, sok ? oh(sim_tag) : 4'h0);
        @(negedge clk);
        m_axis_cmd_tready = 0;
        s_axis_sts_tvalid = 0;
        m_ptr[ch] = wr ? m_base[ch] : p + btt;
        m_last = ch;
        m_out++;
        tagq.push_back(ch);
        if (sok) sts_model(sim_tag, sim_flags);
        #1;
        chk("hs_tvalid_drop", m_axis_cmd_tvalid, 1'b0);
        chk("hs_outstanding", outstanding, 4'(m_out));
        chk("hs_err", ch_err, err_vec());
    endtask

    task automatic drain();
        while (tagq.size() > 0) send_sts(4'(tagq[0]), 4'h8);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_tvalid"}, m_axis_cmd_tvalid, 1'b0);
        chk({nm, "_tdata"}, m_axis_cmd_tdata, 72'h0);
        chk({nm, "_flags"}, {ch_grant, ch_done, ch_err, ch_wrap}, 16'h0);
        chk({nm, "_outstanding"}, outstanding, 4'h0);
    endtask

    initial begin
        bit ok;
        int order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] msk;

        tbl[0]  = '{1, 32'h1000_0000, 32'h3000, 32'h1000_0000, 32'h1000, 0};
        tbl[1]  = '{0, 32'h1000_0000, 32'h3000, 32'h1000_1000, 32'h1000, 0};
        tbl[2]  = '{0, 32'h1000_0000, 32'h3000, 32'h1000_2000, 32'h1000, 1};
        tbl[3]  = '{0, 32'h1000_0000, 32'h3000, 32'h1000_0000, 32'h1000, 0};
        tbl[4]  = '{1, 32'h2000_0000, 32'h2800, 32'h2000_0000, 32'h1000, 0};
        tbl[5]  = '{0, 32'h2000_0000, 32'h2800, 32'h2000_1000, 32'h1000, 0};
        tbl[6]  = '{0, 32'h2000_0000, 32'h2800, 32'h2000_2000, 32'h0800, 1};
        tbl[7]  = '{0, 32'h2000_0000, 32'h2800, 32'h2000_0000, 32'h1000, 0};
        tbl[8]  = '{1, 32'h3000_0040, 32'h0020, 32'h3000_0040, 32'h0020, 1};
        tbl[9]  = '{0, 32'h3000_0040, 32'h0020, 32'h3000_0040, 32'h0020, 1};
        tbl[10] = '{1, 32'h4000_0000, 32'h1020, 32'h4000_0000, 32'h1000, 0};
        tbl[11] = '{0, 32'h4000_0000, 32'h1020, 32'h4000_1000, 32'h0020, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        resetn = 1;
        model_reset();
        @(negedge clk);

        // Ring table on channel 0
        for (int v = 0; v < 12; v++) begin
            if (tbl[v].reload) cfg(0, tbl[v].base, tbl[v].size);
            ch_req = 4'b0001;
            wait_valid(ok);
            if (!ok) fail_timeout("tbl_wait");
            else begin
                chk("tbl_tag", m_axis_cmd_tdata[67:64], 4'h0);
                chk("tbl_ptr", m_axis_cmd_tdata[63:32], tbl[v].ptr);
                chk("tbl_btt", m_axis_cmd_tdata[22:0], tbl[v].btt[22:0]);
                chk("tbl_ctl", m_axis_cmd_tdata[31:23], 9'h181);
                m_axis_cmd_tready = 1;
                #1;
                chk("tbl_grant", ch_grant, 4'h1);
                chk("tbl_wrap", ch_wrap, {3'b0, tbl[v].wrap});
                @(negedge clk);
                m_axis_cmd_tready = 0;
                ch_req = 0;
                m_last = 0; m_out++; tagq.push_back(0);
                m_ptr[0] = tbl[v].wrap ? tbl[v].base : tbl[v].ptr + tbl[v].btt;
                #1 chk("tbl_outstanding", outstanding, 4'(m_out));
                send_sts(4'd0, 4'h8);
            end
        end

        // Eligibility-to-valid latency and the idle gap between commands
        cfg(0, 32'h5000_0000, 32'h0001_0000);
        ch_req = 4'b0001;
        @(negedge clk); chk("lat_cyc1", m_axis_cmd_tvalid, 1'b0);
        @(negedge clk); chk("lat_cyc2", m_axis_cmd_tvalid, 1'b1);
        take_cmd(0, -1, 4'h0);
        @(negedge clk); chk("gap_cyc2", m_axis_cmd_tvalid, 1'b0);
        @(negedge clk); chk("gap_cyc3", m_axis_cmd_tvalid, 1'b1);
        take_cmd(0, -1, 4'h0);
        ch_req = 0;
        drain();

        // Round-robin after reset, with a backpressure stretch on one command
        resetn = 0;
        ch_enable = 0;
        #1 check_reset_state("reset2");
        @(negedge clk);
        resetn = 1;
        model_reset();
        for (int c = 0; c < NCH; c++) cfg(c, 32'h6000_0000 + 32'h0100_0000 * c, 32'h2000);
        ch_req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_valid(ok);
            if (!ok) fail_timeout("rr_wait");
            else chk("rr_order", m_axis_cmd_tdata[67:64], 4'(order[g]));
            take_cmd((g == 2) ? 10 : 0, -1, 4'h0);
            send_sts(4'(tagq[0]), 4'h8);
        end

        // Outstanding limit, then accept and status in the same cycle
        for (int g = 0; g < 4; g++) take_cmd(0, -1, 4'h0);
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            chk("limit_stall", m_axis_cmd_tvalid, 1'b0);
        end
        chk("limit_outstanding", outstanding, 4'd4);
        send_sts(4'd2, 4'h8);
        take_cmd(2, 0, 4'h8);
        ch_req = 0;
        drain();

        // Error status 0x41 on channel 1
        ch_req = 4'b0010;
        take_cmd(0, -1, 4'h0);
        send_sts(4'd1, 4'h4);
        chk("err_ch1", ch_err[1], 1'b1);
`ifdef STS_ERR_HALT_EN
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            chk("halt_no_grant", m_axis_cmd_tvalid, 1'b0);
        end
        cfg(1, m_base[1], m_size[1]);
        take_cmd(0, -1, 4'h0);
`else
        take_cmd(0, -1, 4'h0);
`endif
        ch_req = 0;
        drain();
        cfg(1, m_base[1], m_size[1]);

        // Stray statuses: bad tag with work outstanding, any tag with none
        ch_req = 4'b0001;
        take_cmd(0, -1, 4'h0);
        ch_req = 0;
        send_sts(4'd9, 4'h8);
        drain();
        send_sts(4'd0, 4'h8);

        // Reset while a command is presented
        ch_req = 4'b0100;
        wait_valid(ok);
        if (!ok) fail_timeout("midreset_wait");
        ch_req = 0;
        resetn = 0;
        #1 check_reset_state("midreset");
        @(negedge clk);
        resetn = 1;
        model_reset();
        @(negedge clk);
        send_sts(4'd2, 4'h8);

        // Randomized traffic against the model
        for (int c = 0; c < NCH; c++)
            cfg(c, $urandom & 32'h7FFF_FFE0, 32'($urandom_range(1, 640)) * 32);
        for (int it = 0; it < 150; it++) begin
            if (m_out == 4 || (tagq.size() > 0 && $urandom_range(0, 2) == 0)) begin
                int pick;
                logic [3:0] fl;
                pick = $urandom_range(0, tagq.size() - 1);
                fl = 4'h8;
`ifndef STS_ERR_HALT_EN
                if ($urandom_range(0, 7) == 0) fl = 4'($urandom_range(0, 15));
`endif
                send_sts(4'(tagq[pick]), fl);
            end else if ($urandom_range(0, 15) == 0) begin
                int c;
                c = $urandom_range(0, NCH - 1);
                cfg(c, $urandom & 32'h7FFF_FFE0, 32'($urandom_range(1, 640)) * 32);
            end else begin
                msk = 4'($urandom_range(1, 15));
                ch_req = msk;
                if (tagq.size() > 0 && $urandom_range(0, 3) == 0)
                    take_cmd($urandom_range(0, 3), tagq[0], 4'h8);
                else
                    take_cmd($urandom_range(0, 3), -1, 4'h0);
                ch_req = 0;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axis_s2mm_cmd_sched.md
Name: axis_s2mm_cmd_sched

Overview:
Multi-channel scheduler for one DataMover S2MM command/status pair. Each capture channel owns a circular buffer in DDR and raises a request when a burst of data is staged in its stream FIFO. The block round-robin arbitrates the requests and emits one 72-bit S2MM command per grant, advancing and wrapping each channel's write pointer. It consumes the status stream, routes completions back to the issuing channel, and bounds the number of outstanding commands.

Parameters:
NUM_CH, 4, number of capture channels (1..16; channel index is carried in the command TAG).
BTT_WIDTH, 23, width of the BTT field.
BURST_LEN, 4096, maximum bytes per command.
MAX_OUTSTANDING, 4, maximum accepted commands without a returned status (1..15).

Ports:
clk  in  1  single clock.
resetn  in  1  asynchronous active-low reset.
m_axis_cmd_tdata  out  72  S2MM command.
m_axis_cmd_tvalid  out  1  command valid.
m_axis_cmd_tready  in  1  command ready.
s_axis_sts_tdata  in  8  status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG.
s_axis_sts_tvalid  in  1  status valid.
s_axis_sts_tready  out  1  status ready.
ch_enable  in  NUM_CH  per-channel enable (level).
ch_req  in  NUM_CH  per-channel "burst staged" request (level).
ch_base_addr  in  NUM_CH*32  per-channel ring base; channel i uses bits [32i+31:32i].
ch_ring_size  in  NUM_CH*32  per-channel ring size in bytes; nonzero, multiple of 32.
ch_grant  out  NUM_CH  one-cycle pulse when that channel's command is accepted.
ch_done  out  NUM_CH  one-cycle pulse when status returns for that channel.
ch_err  out  NUM_CH  sticky error flag; cleared when the channel's ch_enable falls.
ch_wrap  out  NUM_CH  one-cycle pulse when the channel's pointer wraps to base.
outstanding  out  4  count of commands accepted but not yet completed.

Behaviour:
- Reset: state IDLE. All outputs are 0: tdata, tvalid, grant, done, err, wrap, outstanding. Every channel's write pointer equals 0.
- ch_enable rising edge (registered compare): the channel's pointer loads from ch_base_addr.
- ch_enable low: the channel is excluded from arbitration. A command already presented (tvalid high) is still held until accepted.
- Channel i is eligible when ch_enable[i], ch_req[i] and !halted[i] are all true, and outstanding < MAX_OUTSTANDING.
- FSM states: IDLE, ARB, SEND.
  - IDLE -> ARB when any channel is eligible.
  - ARB: round-robin pick, starting from the channel after the last granted one (channel 0 first after reset). Latch the channel index. Build the command and register it into tdata with tvalid=1. Go to SEND. Latency from eligibility to tvalid is 2 cycles.
  - SEND: hold tdata and tvalid stable until tready. On the handshake cycle:
    - tvalid drops; ch_grant[i] pulses; outstanding increments.
    - Pointer advances by btt; wrap check as described below.
    - Go to IDLE.
  - No back-to-back commands: minimum 2 idle cycles between commands.
- Command fields:
  - [71:68] = 0.
  - [67:64] = channel index (TAG).
  - [63:32] = pointer.
  - [31] = 1 (S2MM).
  - [30] = 1 (EOF).
  - [29:24] = 0.
  - [23] = 1.
  - [BTT_WIDTH-1:0] = btt.
- btt arithmetic: btt = min(BURST_LEN, base + size - pointer), computed in 32-bit unsigned.
- Wrap: if pointer + btt == base + size, the next pointer is base and ch_wrap[i] pulses together with grant. Otherwise the next pointer is pointer + btt.
- Status: s_axis_sts_tready is tied to 1. On a status beat:
  - ch_done[TAG] pulses.
  - outstanding decrements.
  - If OKAY=0 or any error bit is set, ch_err[TAG] is set.
  - A TAG >= NUM_CH, or a status beat arriving while outstanding==0, is ignored except for setting a global error internally. The counter never underflows.
- Command accept and status in the same cycle: outstanding is unchanged; both grant and done pulse.
- Config changes to base_addr or ring_size while a channel is enabled are undefined. Software disables the channel first.
- Asynchronous reset mid-command drops tvalid immediately. In-flight statuses after reset are treated as the stray statuses described above.

Optional Feature:
STS_ERR_HALT_EN: when defined, an error status sets halted[TAG]. A halted channel is never eligible until its ch_enable is deasserted and reasserted, which also reloads its pointer from base. When not defined, halted is constant 0: errors only set ch_err and the channel keeps being scheduled.

Test Plan:
- Single channel: base 0x1000_0000, size 0x3000, req held, tready=1 -> commands at 0x1000_0000, 0x1000_1000, 0x1000_2000 with btt 0x1000. The 3rd grant pulses ch_wrap. The 4th command is at 0x1000_0000.
- Partial wrap: size 0x2800 -> second command at base+0x1000, third at base+0x2000 with btt 0x800, then wrap to base.
- Round-robin: 4 channels all requesting -> grant order 0,1,2,3,0. Each tdata[67:64] equals the granted index.
- Backpressure: tready low for 10 cycles -> tdata and tvalid stable throughout. The grant pulses exactly on the handshake cycle.
- Outstanding limit: MAX_OUTSTANDING=4, no status returned -> exactly 4 commands, then stall. One status with TAG=2, OKAY=1 -> ch_done[2] pulses and a 5th command issues. Also drive a simultaneous accept+status and check outstanding is unchanged.
- Error status 0x41 (SLVERR, tag 1) -> ch_err[1] set. With STS_ERR_HALT_EN, channel 1 receives no further grants until ch_enable[1] toggles. Without it, channel 1 continues to receive grants.
